// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX tag=value field parser.
package fix_pkg;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_TAG   = 2'd1,
    ERR_TAG_OVF   = 2'd2,
    ERR_VAL_TRUNC = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    S_TAG   = 2'd0,
    S_VALUE = 2'd1,
    S_SKIP  = 2'd2,
    S_EMIT  = 2'd3
  } state_e;

  localparam logic [7:0]  FIX_SOH          = 8'h01;
  localparam logic [7:0]  FIX_SEP          = 8'h3D;
  localparam int unsigned FIX_TAG_CHECKSUM = 10;

endpackage

// File: rtl/fix_tag_accum.sv
// Decimal-to-binary tag accumulator; refuses a digit that would overflow TAG_W
// so the tag keeps the value it had when the error occurred.
module fix_tag_accum #(
  parameter int unsigned TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [TAG_W-1:0] tag,
  output logic             has_digit,
  output logic             ovf_c
);

  localparam int unsigned EXT_W = TAG_W + 4;

  logic [EXT_W-1:0] next_c;

  // tag*10 + digit never exceeds EXT_W bits for any TAG_W-bit tag
  assign next_c = EXT_W'(tag) * EXT_W'(10) + EXT_W'(digit);
  assign ovf_c  = |next_c[EXT_W-1:TAG_W];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tag       <= '0;
      has_digit <= 1'b0;
    end else if (digit_valid && !ovf_c) begin
      tag       <= next_c[TAG_W-1:0];
      has_digit <= 1'b1;
    end
  end

endmodule

// File: rtl/fix_field_parser.sv
// FIX byte-stream field parser: tag digits -> binary tag, value bytes -> buffer,
// one record per SOH-terminated field with error code and running checksum.
module fix_field_parser import fix_pkg::*; #(
  parameter int unsigned TAG_W       = 16,
  parameter int unsigned MAX_VAL_LEN = 32,
  parameter int unsigned LEN_W       = $clog2(MAX_VAL_LEN + 1),
  parameter logic [7:0]  SOH_CHAR    = FIX_SOH,
  parameter logic [7:0]  SEP_CHAR    = FIX_SEP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  output logic                     fld_valid,
  input  logic                     fld_ready,
  output logic [TAG_W-1:0]         fld_tag,
  output logic [LEN_W-1:0]         fld_len,
  output logic [8*MAX_VAL_LEN-1:0] fld_value,
  output logic [1:0]               fld_err,
  output logic [7:0]               fld_csum
);

  state_e                   state_q, state_d;
  logic                     accept_c, handshake_c;
  logic                     is_digit, is_sep, is_soh;
  logic                     digit_valid, store_c, err_set;
  err_e                     err_code;
  logic [TAG_W-1:0]         tag_q;
  logic                     has_digit, ovf_c;
  logic [LEN_W-1:0]         len_q;
  logic [8*MAX_VAL_LEN-1:0] buf_q;
  err_e                     err_q;
  logic [7:0]               sum_q, csum_q;
  logic                     first_q;
  logic                     valid_q;

  assign in_ready    = !rst && (state_q != S_EMIT);
  assign accept_c    = in_valid && in_ready;
  assign handshake_c = valid_q && fld_ready;
  assign is_digit    = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_sep      = (in_data == SEP_CHAR);
  assign is_soh      = (in_data == SOH_CHAR);

  fix_tag_accum #(.TAG_W(TAG_W)) u_tag_accum (
    .clk         (clk),
    .rst         (rst),
    .clr         (handshake_c),
    .digit_valid (digit_valid),
    .digit       (in_data[3:0]),
    .tag         (tag_q),
    .has_digit   (has_digit),
    .ovf_c       (ovf_c)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_TAG;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TAG: begin
        if (accept_c) begin
          if (is_digit) begin
            if (ovf_c) state_d = S_SKIP;
          end else if (is_sep) begin
            state_d = has_digit ? S_VALUE : S_SKIP;
          end else if (is_soh) begin
            state_d = S_EMIT;
          end else begin
            state_d = S_SKIP;
          end
        end
      end
      S_VALUE, S_SKIP: if (accept_c && is_soh) state_d = S_EMIT;
      S_EMIT:          if (fld_ready) state_d = S_TAG;
      default:         state_d = S_TAG;
    endcase
  end

  // datapath strobes decoded from state and the accepted byte
  always_comb begin
    digit_valid = 1'b0;
    store_c     = 1'b0;
    err_set     = 1'b0;
    err_code    = ERR_NONE;
    case (state_q)
      S_TAG: begin
        if (accept_c) begin
          if (is_digit) begin
            digit_valid = 1'b1;
            if (ovf_c) begin
              err_set  = 1'b1;
              err_code = ERR_TAG_OVF;
            end
          end else if (!(is_sep && has_digit)) begin
            err_set  = 1'b1;
            err_code = ERR_BAD_TAG;
          end
        end
      end
      S_VALUE: begin
        if (accept_c && !is_soh) begin
          if (32'(len_q) < MAX_VAL_LEN) begin
            store_c = 1'b1;
          end else begin
            err_set  = 1'b1;
            err_code = ERR_VAL_TRUNC;
          end
        end
      end
      default: ;
    endcase
  end

  // value buffer, error, checksum and record-valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      buf_q   <= '0;
      err_q   <= ERR_NONE;
      sum_q   <= 8'h00;
      csum_q  <= 8'h00;
      first_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      if (accept_c) begin
        sum_q <= sum_q + in_data;
        if (first_q) begin
          csum_q  <= sum_q;
          first_q <= 1'b0;
        end
        if (state_d == S_EMIT) valid_q <= 1'b1;
      end
      if (store_c) begin
        buf_q[32'(len_q)*8 +: 8] <= in_data;
        len_q                    <= len_q + LEN_W'(1);
      end
      if (err_set && (err_q == ERR_NONE)) err_q <= err_code;
      if (handshake_c) begin
        valid_q <= 1'b0;
        len_q   <= '0;
        buf_q   <= '0;
        err_q   <= ERR_NONE;
        first_q <= 1'b1;
        if ((tag_q == TAG_W'(FIX_TAG_CHECKSUM)) && (err_q == ERR_NONE)) sum_q <= 8'h00;
      end
    end
  end

  assign fld_valid = valid_q;
  assign fld_tag   = tag_q;
  assign fld_len   = len_q;
  assign fld_value = buf_q;
  assign fld_err   = err_q;
  assign fld_csum  = csum_q;

endmodule

// File: tb/tb_fix_field_parser.sv
// Directed scoreboard bench for fix_field_parser (TAG_W=8, MAX_VAL_LEN=4).
module tb_fix_field_parser;

  localparam int unsigned TAG_W = 8;
  localparam int unsigned MAXV  = 4;
  localparam int unsigned LEN_W = 3;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [LEN_W-1:0] len;
    logic [8*MAXV-1:0] val;
    logic [1:0]       err;
    logic [7:0]       csum;
    bit               chk_tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'h00;
  logic              fld_valid;
  logic              fld_ready = 1'b1;
  logic [TAG_W-1:0]  fld_tag;
  logic [LEN_W-1:0]  fld_len;
  logic [8*MAXV-1:0] fld_value;
  logic [1:0]        fld_err;
  logic [7:0]        fld_csum;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [7:0] model_sum = 8'h00;

  fix_field_parser #(.TAG_W(TAG_W), .MAX_VAL_LEN(MAXV)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .fld_valid (fld_valid),
    .fld_ready (fld_ready),
    .fld_tag   (fld_tag),
    .fld_len   (fld_len),
    .fld_value (fld_value),
    .fld_err   (fld_err),
    .fld_csum  (fld_csum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  // Pop and compare each record at the negedge before its handshake edge
  always @(negedge clk) begin
    if (!rst && fld_valid && fld_ready) begin
      chk("record_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_tag) chk("fld_tag", 32'(fld_tag), 32'(e.tag));
        chk("fld_len", 32'(fld_len), 32'(e.len));
        chk("fld_value", fld_value, e.val);
        chk("fld_err", 32'(fld_err), 32'(e.err));
        chk("fld_csum", 32'(fld_csum), 32'(e.csum));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    model_sum = model_sum + b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_field(input string s, input logic [TAG_W-1:0] tag, input logic [LEN_W-1:0] len,
                            input logic [8*MAXV-1:0] val, input logic [1:0] err, input bit chk_tag);
    exp_t e;
    e.tag = tag; e.len = len; e.val = val; e.err = err; e.csum = model_sum; e.chk_tag = chk_tag;
    sb.push_back(e);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h01);
    chk("valid_latency", 32'(fld_valid), 32'd1);
    if (tag == TAG_W'(10) && err == 2'd0) model_sum = 8'h00;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || fld_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 50), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fld_valid", 32'(fld_valid), 32'd0);
    chk("rst_fld_tag", 32'(fld_tag), 32'd0);
    chk("rst_fld_len", 32'(fld_len), 32'd0);
    chk("rst_fld_value", fld_value, 32'd0);
    chk("rst_fld_err", 32'(fld_err), 32'd0);
    chk("rst_fld_csum", 32'(fld_csum), 32'd0);
    rst = 1'b0;
    model_sum = 8'h00;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    do_reset();

    // basic record
    fld_ready = 1'b1;
    send_field("35=D", 8'd35, 3'd1, 32'h0000_0044, 2'd0, 1'b1);
    drain();

    // backpressure: record held, next field's first byte waits
    fld_ready = 1'b0;
    send_field("35=D", 8'd35, 3'd1, 32'h0000_0044, 2'd0, 1'b1);
    in_valid = 1'b1;
    in_data  = "4";
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(fld_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_tag", 32'(fld_tag), 32'd35);
      chk("stall_value", fld_value, 32'h0000_0044);
      @(negedge clk);
    end
    fld_ready = 1'b1;
    send_field("49=AB", 8'd49, 3'd2, 32'h0000_4241, 2'd0, 1'b1);

    // truncation, malformed tags, empty value
    send_field("58=HELLOWORLD", 8'd58, 3'd4, 32'h4C4C_4548, 2'd3, 1'b1);
    send_field("3A=X", 8'd3, 3'd0, 32'h0, 2'd1, 1'b1);
    send_field("1=Y", 8'd1, 3'd1, 32'h0000_0059, 2'd0, 1'b1);
    send_field("=X", 8'd0, 3'd0, 32'h0, 2'd1, 1'b1);
    send_field("1=Y", 8'd1, 3'd1, 32'h0000_0059, 2'd0, 1'b1);
    send_field("300=X", 8'd0, 3'd0, 32'h0, 2'd2, 1'b0);
    send_field("1=Y", 8'd1, 3'd1, 32'h0000_0059, 2'd0, 1'b1);
    send_field("4", 8'd4, 3'd0, 32'h0, 2'd1, 1'b1);
    send_field("5=", 8'd5, 3'd0, 32'h0, 2'd0, 1'b1);
    drain();

    // checksum field clears the accumulator
    do_reset();
    send_field("8=A", 8'd8, 3'd1, 32'h0000_0041, 2'd0, 1'b1);
    send_field("10=000", 8'd10, 3'd3, 32'h0030_3030, 2'd0, 1'b1);
    send_field("9=Z", 8'd9, 3'd1, 32'h0000_005A, 2'd0, 1'b1);
    drain();

    // reset mid-field discards the partial record
    send_byte("1"); send_byte("2"); send_byte("="); send_byte("A"); send_byte("B");
    do_reset();
    send_field("7=Q", 8'd7, 3'd1, 32'h0000_0051, 2'd0, 1'b1);
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
